// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reversal helper used to locate results.
// Latency: n/a (package only).
// Backpressure: n/a.
package fft_pkg;

  localparam int FFT_N  = 64;
  localparam int ADDR_W = 5;
  localparam int IDX_W  = 6;

  // Mirror a 6-bit index: bit i of the result is bit (5-i) of the input.
  function automatic logic [IDX_W-1:0] bitrev6(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) begin
      r[i] = v[IDX_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry output buffer between the bank read path and the result stream.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: full/empty exported; push while full is accepted only with a same-cycle pop.
//
// Ports: clk, nrst (async active-low); push/push_data write side;
//        pop/pop_data read side (pop_data is the current head); full, empty status.
module fft_out_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [1:0][DATA_W-1:0] mem_q, mem_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   do_push, do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign do_pop   = pop & ~empty;
  // When full, the slot being popped is the slot being written, so a
  // simultaneous push/pop is safe and leaves the count unchanged.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_output_reader.sv
// Unloads the 64 bit-reversed FFT results from two banks as a natural-order stream.
// Latency: first out_valid two cycles after start is sampled; one word/cycle when out_ready stays high.
// Backpressure: reads are throttled so buffered + in-flight words never exceed two; nothing is dropped.
//
// Ports: clk, nrst (async active-low); start (one-cycle pulse, ignored while busy);
//        re_b0/re_b1, raddr_b0/raddr_b1, rdata_b0/rdata_b1 bank read ports (1-cycle read latency);
//        out_data/out_index/out_last with out_valid/out_ready handshake; busy; done (one-cycle pulse).
module fft_output_reader
  import fft_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  output logic              re_b0,
  output logic              re_b1,
  output logic [ADDR_W-1:0] raddr_b0,
  output logic [ADDR_W-1:0] raddr_b1,
  input  logic [DATA_W-1:0] rdata_b0,
  input  logic [DATA_W-1:0] rdata_b1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_t;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(FFT_N - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;              // next frequency index to read
  logic               inflight_q, inflight_d;
  logic               inflight_bank_q, inflight_bank_d;
  logic [IDX_W-1:0]   inflight_idx_q, inflight_idx_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]        k_rev;
  logic                    rd_bank;
  logic [ADDR_W-1:0]       rd_addr;
  logic [1:0]              occ;
  logic [2:0]              budget;
  logic                    issue, pop;
  logic                    fifo_full, fifo_empty;
  logic [DATA_W-1:0]       rdata_sel;
  logic [DATA_W+IDX_W-1:0] push_word, head_word;

  assign k_rev   = bitrev6(k_q);
  // Parity of the reversed index equals parity of k itself.
  assign rd_bank = ^k_rev;
  assign rd_addr = k_rev[IDX_W-1:1];

  assign occ = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pop = ~fifo_empty & out_ready;
  // Occupancy after this cycle's pop plus the read already in flight; a new
  // read is allowed only if its word will still have a slot when it lands.
  // Counting the pop is what lets the stream sustain one word per cycle.
  assign budget = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == ST_READ) && (budget < 3'd2);

  assign re_b0    = issue & ~rd_bank;
  assign re_b1    = issue & rd_bank;
  assign raddr_b0 = re_b0 ? rd_addr : '0;
  assign raddr_b1 = re_b1 ? rd_addr : '0;

  assign rdata_sel = inflight_bank_q ? rdata_b1 : rdata_b0;
  assign push_word = {inflight_idx_q, rdata_sel};

  fft_out_fifo #(
    .DATA_W (DATA_W + IDX_W)
  ) u_out_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (inflight_q),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Payload is gated so the stream reads as all-zero whenever nothing is valid.
  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? head_word[DATA_W-1:0] : '0;
  assign out_index = out_valid ? head_word[DATA_W +: IDX_W] : '0;
  assign out_last  = out_valid & (out_index == K_LAST);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    inflight_d      = issue;
    inflight_bank_d = inflight_bank_q;
    inflight_idx_d  = inflight_idx_q;
    done_d          = 1'b0;
    if (issue) begin
      inflight_bank_d = rd_bank;
      inflight_idx_d  = k_q;
    end
    unique case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (start) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          k_d = k_q + IDX_W'(1);
          if (k_q == K_LAST) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= ST_IDLE;
      k_q             <= '0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      inflight_idx_q  <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      inflight_idx_q  <= inflight_idx_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_output_reader.sv
// Directed bench for fft_output_reader with a two-bank memory model.
// Latency: n/a.
// Backpressure: out_ready driven per step from the stimulus sequence.
module tb_fft_output_reader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        re_b0, re_b1;
  logic [4:0]  raddr_b0, raddr_b1;
  logic [31:0] rdata_b0 = 32'd0;
  logic [31:0] rdata_b1 = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic [5:0]  out_index;
  logic        out_last, busy, done;

  int checks = 0;
  int failures = 0;

  // model state
  int exp_k, rd_k, n_xfer, n_done, cyc_cnt, first_v, last_x;
  bit prev_stall, last63_prev;
  logic [38:0] prev_word;

  wire [53:0] all_out = {re_b0, re_b1, raddr_b0, raddr_b1, out_data,
                         out_valid, out_index, out_last, busy, done};

  always #5 clk = ~clk;

  fft_output_reader #(.DATA_W(32)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .re_b0     (re_b0),
    .re_b1     (re_b1),
    .raddr_b0  (raddr_b0),
    .raddr_b1  (raddr_b1),
    .rdata_b0  (rdata_b0),
    .rdata_b1  (rdata_b1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [5:0] brev(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  // Each bank location holds its own 6-bit storage index r, where
  // r[5:1] is the address and r[0] makes parity(r) equal the bank number.
  function automatic logic [31:0] stor(input logic b, input logic [4:0] a);
    return {26'd0, a, (^a) ^ b};
  endfunction

  always @(posedge clk) begin
    rdata_b0 <= re_b0 ? stor(1'b0, raddr_b0) : 32'hDEAD_BEEF;
    rdata_b1 <= re_b1 ? stor(1'b1, raddr_b1) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_frame();
    exp_k = 0; rd_k = 0; n_xfer = 0; n_done = 0; cyc_cnt = 0;
    first_v = -1; last_x = -1; prev_stall = 0; last63_prev = 0;
    prev_word = '0;
  endtask

  task automatic pulse_start(input logic rdy);
    @(negedge clk);
    start = 1'b1;
    out_ready = rdy;
  endtask

  // One clock step: drive inputs at the falling edge, then check the
  // settled outputs against the reference model.
  task automatic cyc(input logic rdy, input logic st);
    logic [5:0] kk;
    logic [5:0] rr;
    @(negedge clk);
    out_ready = rdy;
    start = st;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_word", 64'({out_index, out_last, out_data}), 64'(prev_word));
    end
    prev_stall = out_valid && !out_ready;
    prev_word = {out_index, out_last, out_data};
    if (done || last63_prev) begin
      chk("done_pulse", 64'({done, busy}), 64'({last63_prev, 1'b0}));
    end
    if (done) n_done++;
    last63_prev = 0;
    if (out_valid) begin
      if (first_v < 0) first_v = cyc_cnt;
      chk("last_flag", 64'(out_last), 64'(out_index == 6'd63));
    end
    if (out_valid && out_ready) begin
      kk = exp_k[5:0];
      chk("xfer_index", 64'(out_index), 64'(kk));
      chk("xfer_data", 64'(out_data), 64'({26'd0, brev(kk)}));
      last63_prev = (kk == 6'd63);
      exp_k++;
      n_xfer++;
      last_x = cyc_cnt;
    end
    if (re_b0 || re_b1) begin
      kk = rd_k[5:0];
      rr = brev(kk);
      chk("read_bank", 64'({re_b1, re_b0}), 64'((^kk) ? 2'b10 : 2'b01));
      chk("read_addr", 64'({raddr_b1, raddr_b0}),
          64'((^kk) ? {rr[5:1], 5'd0} : {5'd0, rr[5:1]}));
      rd_k++;
      chk("outstanding_le2", 64'((rd_k - n_xfer) <= 2), 64'd1);
    end else begin
      chk("raddr_idle", 64'({raddr_b1, raddr_b0}), 64'd0);
    end
    cyc_cnt++;
  endtask

  initial begin
    new_frame();

    // Reset state
    @(negedge clk); #1;
    chk("reset_outputs", 64'(all_out), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("idle_after_reset", 64'(all_out), 64'd0);

    // Full-rate unload, out_ready held high
    new_frame();
    pulse_start(1'b1);
    for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0);
    chk("full_first_valid_cyc", 64'(first_v), 64'd2);
    chk("full_last_xfer_cyc", 64'(last_x), 64'd65);
    chk("full_xfers", 64'(n_xfer), 64'd64);
    chk("full_reads", 64'(rd_k), 64'd64);
    chk("full_done_count", 64'(n_done), 64'd1);
    chk("full_busy_end", 64'(busy), 64'd0);

    // Stall for 5 cycles with k=10 at the head
    new_frame();
    pulse_start(1'b1);
    for (int i = 0; i < 200 && exp_k < 10; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    chk("stall_index", 64'(out_index), 64'd10);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_reads_issued", 64'(rd_k), 64'd12);
    for (int i = 0; i < 200 && n_done == 0; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("stall_xfers", 64'(n_xfer), 64'd64);
    chk("stall_done_count", 64'(n_done), 64'd1);

    // Random 50% out_ready
    new_frame();
    pulse_start(1'($urandom_range(0, 1)));
    for (int i = 0; i < 600 && n_done == 0; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
    chk("rand_xfers", 64'(n_xfer), 64'd64);
    chk("rand_done_count", 64'(n_done), 64'd1);
    chk("rand_busy_end", 64'(busy), 64'd0);

    // Reset in the middle of the unload at k=40
    new_frame();
    pulse_start(1'b1);
    for (int i = 0; i < 200 && exp_k < 40; i++) cyc(1'b1, 1'b0);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("midrst_outputs", 64'(all_out), 64'd0);
    @(negedge clk); #1;
    chk("midrst_outputs_held", 64'(all_out), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    new_frame();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("midrst_no_resume", 64'({busy, out_valid}), 64'd0);
    chk("midrst_no_reads", 64'(rd_k), 64'd0);
    new_frame();
    pulse_start(1'b1);
    for (int i = 0; i < 200 && n_done == 0; i++) cyc(1'b1, 1'b0);
    chk("restart_xfers", 64'(n_xfer), 64'd64);
    chk("restart_first_valid_cyc", 64'(first_v), 64'd2);
    chk("restart_done_count", 64'(n_done), 64'd1);

    // start re-pulsed while busy at k=20
    new_frame();
    pulse_start(1'b1);
    for (int i = 0; i < 200 && exp_k < 20; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 200 && n_done == 0; i++) cyc(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("repulse_xfers", 64'(n_xfer), 64'd64);
    chk("repulse_reads", 64'(rd_k), 64'd64);
    chk("repulse_done_count", 64'(n_done), 64'd1);
    chk("repulse_idle", 64'({busy, out_valid}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
